// File: rtl/camera_config_sequencer.sv
// Walks a register table from ROM and issues one bus write per entry.
// Optional CAM_CFG_DELAY_OP_EN turns reg_addr 8'hFE entries into timed waits.
module camera_config_sequencer #(
  parameter logic [6:0] CAM_I2C_ADDR = 7'h3C,
  parameter int         NUM_ENTRIES  = 8,
  parameter int         DELAY_TICKS  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        reg_wr_start,
  input  logic        reg_wr_done,
  input  logic        reg_wr_ready
);

  // Writer handshake: reg_wr_start is a one-clk command pulse, only issued while
  // reg_wr_ready=1; the command is complete when reg_wr_done is sampled high.
  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    FETCH_WAIT,
    DECODE,
    WAIT_READY,
    ISSUE,
    WAIT_DONE,
    NEXT,
    FINISH
`ifdef CAM_CFG_DELAY_OP_EN
    , DELAY
`endif
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] index;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_data_q;

`ifdef CAM_CFG_DELAY_OP_EN
  // 255 * DELAY_TICKS always fits in 8 + clog2(DELAY_TICKS) bits.
  localparam int DW = 8 + $clog2(DELAY_TICKS);
  logic [DW-1:0] delay_cnt;
  logic          is_delay;
  assign is_delay = (tbl_data[15:8] == 8'hFE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cfg_busy     = 1'b1;
    cfg_done     = 1'b0;
    reg_wr_start = 1'b0;
    case (state)
      IDLE: begin
        cfg_busy = 1'b0;
        if (cfg_start) state_nxt = FETCH;
      end
      FETCH:      state_nxt = FETCH_WAIT;
      FETCH_WAIT: state_nxt = DECODE;
      DECODE: begin
`ifdef CAM_CFG_DELAY_OP_EN
        state_nxt = is_delay ? DELAY : WAIT_READY;
`else
        state_nxt = WAIT_READY;
`endif
      end
      WAIT_READY: if (reg_wr_ready) state_nxt = ISSUE;
      ISSUE: begin
        reg_wr_start = 1'b1;
        state_nxt    = WAIT_DONE;
      end
      WAIT_DONE: if (reg_wr_done) state_nxt = NEXT;
`ifdef CAM_CFG_DELAY_OP_EN
      // A zero-length delay leaves after its single pass through this state.
      DELAY: if (delay_cnt <= DW'(1)) state_nxt = NEXT;
`endif
      NEXT: state_nxt = (index == LAST_IDX) ? FINISH : FETCH;
      FINISH: begin
        cfg_busy  = 1'b0;
        cfg_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index      <= 8'd0;
      reg_addr_q <= 8'd0;
      reg_data_q <= 8'd0;
    end else begin
      if (state == IDLE && cfg_start)
        index <= 8'd0;
      else if (state == NEXT && index != LAST_IDX)
        index <= index + 8'd1;
      // Held from DECODE until the writer reports completion.
      if (state == DECODE) begin
        reg_addr_q <= tbl_data[15:8];
        reg_data_q <= tbl_data[7:0];
      end
    end
  end

`ifdef CAM_CFG_DELAY_OP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      delay_cnt <= '0;
    else if (state == DECODE)
      delay_cnt <= DW'(tbl_data[7:0]) * DW'(DELAY_TICKS);
    else if (state == DELAY && delay_cnt != '0)
      delay_cnt <= delay_cnt - DW'(1);
  end
`endif

  assign tbl_addr = index;
  assign i2c_addr = CAM_I2C_ADDR;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;

endmodule
